ram_sp_param: RTL
=================

Name: ram_sp_param

Overview:
- Parametrised single-port synchronous RAM of DEPTH words x WIDTH bits. It is the next generation of the 1x8/2x8 register RAMs, and replaces the cascaded 1-word instances with one addressable array.
- Adds a hardware clear sequencer after reset, a registered read with a valid strobe, and address range checking.
- Used as a generic scratch memory in the guide datapaths.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 4, number of words (>=2; need not be a power of two)
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset
- en  input  1  request strobe; a request is accepted on a rising edge with en=1 and busy=0
- r_w  input  1  0 = read, 1 = write
- addr  input  ADDR_W  word address
- data_in  input  WIDTH  write data
- data_out  output  WIDTH  registered read data
- rd_valid  output  1  one-cycle pulse: data_out updated by a read
- busy  output  1  clear sequence in progress; requests ignored
- addr_err  output  1  one-cycle pulse: accepted request had addr >= DEPTH
- par_err  output  1  one-cycle pulse with rd_valid on a parity mismatch (see Optional Feature)

Behaviour:
- Reset: synchronous, active-low. rst=0 at a rising edge resets the block.
- Values while rst=0 at each edge:
  - data_out = 0, rd_valid = 0, addr_err = 0, par_err = 0
  - busy = 1
  - FSM in CLEAR, clear pointer = 0
- Array contents are not directly reset; the CLEAR state clears them.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each edge with rst=1 writes 0 to word[ptr], then increments ptr.
  - On the edge that writes word DEPTH-1, go to READY; busy falls after that edge.
  - Total busy time after rst release is exactly DEPTH cycles.
- READY: busy = 0. The FSM stays in READY until the next reset.
- Reset during CLEAR or READY: on the next edge with rst=0, return to CLEAR with ptr = 0. Clearing restarts from word 0.
- Requests with busy=1: ignored entirely. No array change, no rd_valid, no addr_err.
- Accepted write (r_w=1): word[addr] <= data_in on that edge.
  - rd_valid stays 0.
  - data_out holds its value.
- Accepted read (r_w=0):
  - data_out <= word[addr] on that edge, so latency is 1 cycle.
  - rd_valid = 1 for exactly the following cycle.
- Read-after-write to the same address on consecutive cycles returns the new data. There is no bypass hazard, because the write completes on the earlier edge.
- Out-of-range request (addr >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - Write: discarded.
  - Read: data_out <= 0 and rd_valid pulses.
  - In both cases addr_err pulses for one cycle, aligned with where rd_valid would be.
- No accepted read: data_out holds its last value and is never X. rd_valid = 0.
- en=0: no operation. All pulse outputs are 0 the next cycle.
- Back-to-back reads on consecutive cycles: rd_valid stays high continuously, and data_out updates every cycle.

Optional Feature:
- Macro: RAM_SP_PARITY_EN
- Defined:
  - Each word stores WIDTH+1 bits: data plus even parity (the XOR of the data bits).
  - Writes store the parity of data_in.
  - CLEAR writes data = 0 with parity = 0.
  - On an accepted in-range read, stored parity is compared with the recomputed parity. A mismatch sets par_err = 1 in the same cycle as rd_valid.
  - data_out still returns the stored data.
- Not defined:
  - No parity storage; the array is WIDTH bits.
  - par_err is tied to 0.
  - The port list is identical in both builds.

Test Plan:
- Clear sequence and readback:
  - DEPTH=4. Hold rst=0 for 2 cycles, then release.
  - busy must be 1 for exactly 4 cycles, then 0.
  - Reads of addresses 0..3 must return 8'h00 with rd_valid, one cycle after each request.
- Write/read:
  - Write 8'hAA to addr 0 and 8'hFF to addr 1.
  - Read addr 0 then addr 1 on consecutive cycles.
  - data_out must be 8'hAA then 8'hFF; rd_valid must be high 2 cycles.
  - data_out must hold 8'hFF afterwards.
- Busy blocking and reset mid-clear:
  - DEPTH=8. Assert rst=0 for 1 cycle at clear cycle 3, and issue a write of 8'h55 to addr 7 while busy.
  - busy must restart and last 8 cycles.
  - A subsequent read of addr 7 must return 8'h00.
- Out-of-range:
  - DEPTH=3, ADDR_W=2. Write 8'h12 to addr 3, then read addr 3.
  - addr_err must pulse on both requests.
  - The read must return 8'h00 with rd_valid=1.
  - Words 0..2 must be unchanged.
- Read-after-write:
  - Write 8'h3C to addr 2 in cycle n, then read addr 2 in cycle n+1.
  - data_out must be 8'h3C in cycle n+2.
- Parity (RAM_SP_PARITY_EN defined):
  - Write 8'h01, then force-flip the stored parity bit of that word hierarchically, then read it.
  - par_err must be 1 alongside rd_valid, and data_out must be 8'h01.
  - Without the macro, par_err must stay 0 throughout.

Source files
------------

// File: rtl/ram_sp_param.sv
// ram_sp_param: DEPTH x WIDTH single-port RAM with post-reset clear sequencer, registered read and range check.
// Define RAM_SP_PARITY_EN to store an even-parity bit per word and flag read mismatches on par_err.
module ram_sp_param #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              r_w,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              addr_err,
    output logic              par_err
);
`ifdef RAM_SP_PARITY_EN
    localparam int WW = WIDTH + 1;
`else
    localparam int WW = WIDTH;
`endif
    typedef enum logic {CLEAR, READY} state_t;
    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [WW-1:0]     mem [DEPTH];
    logic [WW-1:0]     wr_word, rd_word;
    logic              in_range, accept, rd_acc;
    assign busy     = state == CLEAR;
    assign in_range = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
    assign accept   = en && !busy;
    assign rd_acc   = accept && !r_w;
    assign rd_word  = in_range ? mem[addr] : '0;
`ifdef RAM_SP_PARITY_EN
    assign wr_word = {^data_in, data_in};
`else
    assign wr_word = data_in;
`endif
    always_comb begin
        state_n = (busy && ptr == ADDR_W'(DEPTH - 1)) ? READY : state;
        ptr_n   = busy ? ptr + 1'b1 : ptr;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end
    // The array itself has no reset; the clear sequencer zeroes it word by word.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (busy)
                mem[ptr] <= '0;
            else if (accept && r_w && in_range)
                mem[addr] <= wr_word;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            addr_err <= accept && !in_range;
            if (rd_acc)
                data_out <= rd_word[WIDTH-1:0];
        end
    end
`ifdef RAM_SP_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst)
            par_err <= 1'b0;
        else
            par_err <= rd_acc && in_range && (^rd_word);
    end
`else
    assign par_err = 1'b0;
`endif
endmodule
